// File: rtl/request_latch4.sv
// Request front end: per-channel synchroniser, lockout debounce and rising-edge
// detect feeding a sticky pending vector that the consumer clears by index.
module request_latch4 #(
  parameter  int WIDTH        = 4,
  parameter  int SYNC_STAGES  = 2,
  parameter  int LOCKOUT_BITS = 16,
  localparam int IDX_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic             VALID,
  input  logic             ACK,
  input  logic [IDX_W-1:0] ACK_IDX,
  output logic             OVERRUN
);

  logic [WIDTH-1:0]        sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]        hist_q;
  logic [LOCKOUT_BITS-1:0] cnt_q  [WIDTH];
  logic [WIDTH-1:0]        pend_q;
  logic                    valid_q;
  logic                    ovr_q;

  logic [WIDTH-1:0]        rise;
  logic [WIDTH-1:0]        acc;
  logic [WIDTH-1:0]        clr;
  logic [WIDTH-1:0]        pend_d;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= I;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    rise = sync_q[SYNC_STAGES-1] & ~hist_q;
    acc  = '0;
    clr  = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      acc[k] = rise[k] && (cnt_q[k] == '0);
      // ACK_IDX values >= WIDTH match no channel and so clear nothing
      clr[k] = ACK && (ACK_IDX == IDX_W'(k));
    end
    pend_d = acc | (pend_q & ~clr);
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int unsigned k = 0; k < WIDTH; k++) cnt_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < WIDTH; k++) begin
        if (acc[k])
          cnt_q[k] <= '1;
        else if (cnt_q[k] != '0)
          cnt_q[k] <= cnt_q[k] - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= |pend_d;
      ovr_q   <= |(acc & pend_q & ~clr);
    end
  end

  assign O       = pend_q;
  assign VALID   = valid_q;
  assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_request_latch4.sv
// Bench for request_latch4: directed scenarios followed by random pin/ACK traffic,
// all checked against a timestamp-based reference model.
module tb_request_latch4;

  localparam int W    = 4;
  localparam int SS   = 2;
  localparam int LB   = 4;
  localparam int LOCK = 1 << LB;

  logic         CLK = 1'b0;
  logic         RESETN = 1'b0;
  logic [W-1:0] I = '0;
  logic [W-1:0] O;
  logic         VALID;
  logic         ACK = 1'b0;
  logic [1:0]   ACK_IDX = '0;
  logic         OVERRUN;

  always #5 CLK = ~CLK;

  request_latch4 #(.WIDTH(W), .SYNC_STAGES(SS), .LOCKOUT_BITS(LB)) dut (
    .CLK(CLK), .RESETN(RESETN), .I(I), .O(O), .VALID(VALID),
    .ACK(ACK), .ACK_IDX(ACK_IDX), .OVERRUN(OVERRUN)
  );

  int checks = 0;
  int errors = 0;

  // Model: pin samples per edge, edge number of each channel's last accepted event.
  logic [W-1:0] samp [SS+1];
  int           last_acc [W];
  logic [W-1:0] m_p;
  logic         m_ovr;
  int           cyc = 0;

  function automatic void model_reset();
    for (int i = 0; i <= SS; i++) samp[i] = '0;
    for (int k = 0; k < W; k++) last_acc[k] = cyc - LOCK;
    m_p   = '0;
    m_ovr = 1'b0;
  endfunction

  function automatic void model_edge();
    logic [W-1:0] seen, prev, acc, clr;
    seen = samp[SS-1];
    prev = samp[SS];
    acc  = '0;
    clr  = ACK ? (W'(1) << ACK_IDX) : '0;
    for (int k = 0; k < W; k++) begin
      if (seen[k] && !prev[k] && (cyc - last_acc[k] >= LOCK)) begin
        acc[k]      = 1'b1;
        last_acc[k] = cyc;
      end
    end
    m_ovr = |(acc & m_p & ~clr);
    m_p   = acc | (m_p & ~clr);
    for (int i = SS; i > 0; i--) samp[i] = samp[i-1];
    samp[0] = I;
    cyc++;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk("O", O, m_p);
    chk("VALID", VALID, m_p != '0);
    chk("OVERRUN", OVERRUN, m_ovr);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int pulses;
    model_reset();
    #12;
    chk("rst_O", O, 0);
    chk("rst_VALID", VALID, 0);
    chk("rst_OVERRUN", OVERRUN, 0);
    @(negedge CLK);
    RESETN = 1'b1;

    // 1: latency from pin rise to pending bit
    I[2] = 1'b1;
    step(); chk("lat_e0", O, 4'b0000);
    step(); chk("lat_e1", O, 4'b0000);
    step(); chk("lat_e2", O, 4'b0100); chk("lat_valid", VALID, 1);

    // 2: acknowledge clears in one cycle
    ACK = 1'b1; ACK_IDX = 2'd2;
    step();
    ACK = 1'b0; I[2] = 1'b0;
    chk("ack_O", O, 4'b0000); chk("ack_valid", VALID, 0); chk("ack_ovr", OVERRUN, 0);

    // 3: bounce on ch0 gives a single event; cleared bit stays clear during lockout
    I[0] = 1'b1; step();
    I[0] = 1'b0; step();
    I[0] = 1'b1; step();
    chk("bounce_set", O, 4'b0001);
    ACK = 1'b1; ACK_IDX = 2'd0;
    I[0] = 1'b0; step();
    ACK = 1'b0;
    I[0] = 1'b1; step();
    I[0] = 1'b0; steps(14);
    chk("bounce_locked", O, 4'b0000);

    // 4: re-trigger while pending merges and pulses OVERRUN once
    I[0] = 1'b1; steps(3);
    chk("ovr_pend", O, 4'b0001);
    I[0] = 1'b0; steps(LOCK + 2);
    I[0] = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      pulses += int'(OVERRUN);
    end
    chk("ovr_pulses", pulses, 1);
    chk("ovr_O", O, 4'b0001);

    // 5: set wins over a simultaneous clear
    ACK = 1'b1; ACK_IDX = 2'd0; step(); ACK = 1'b0;
    I[1] = 1'b1; steps(3);
    chk("swin_pre", O, 4'b0010);
    I[1] = 1'b0; steps(LOCK + 2);
    I[1] = 1'b1; steps(2);
    ACK = 1'b1; ACK_IDX = 2'd1;
    step();
    ACK = 1'b0;
    chk("swin_O", O, 4'b0010); chk("swin_ovr", OVERRUN, 0);

    // 6: ACK of non-pending channel, then ch0, then asynchronous reset
    I[0] = 1'b0; I[3] = 1'b1; steps(LOCK + 2);
    I[0] = 1'b1; steps(3);
    chk("multi_O", O, 4'b1011);
    ACK = 1'b1; ACK_IDX = 2'd2; step();
    chk("nop_ack", O, 4'b1011);
    ACK_IDX = 2'd0; step();
    chk("ack0", O, 4'b1010);
    ACK = 1'b0;
    #2 RESETN = 1'b0;
    #1;
    chk("async_O", O, 4'b0000); chk("async_valid", VALID, 0);
    model_reset();

    // Pin held high across reset release yields exactly one event
    I = 4'b0100;
    @(negedge CLK); RESETN = 1'b1;
    steps(3);
    chk("held_O", O, 4'b0100);
    ACK = 1'b1; ACK_IDX = 2'd2; step(); ACK = 1'b0;
    steps(LOCK + 4);
    chk("held_once", O, 4'b0000);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < W; k++)
        if ($urandom_range(7) == 0) I[k] = ~I[k];
      ACK     = ($urandom_range(3) == 0);
      ACK_IDX = 2'($urandom_range(3));
      step();
    end
    ACK = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
